// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter
//
// Purpose:
//    Arbitrates two write requesters (A and B) onto a single register-file
//    write port, and runs a clear sequence that zeroes every register in
//    address order when asked.
//    - Normal operation is round-robin between A and B. The pointer
//      favours the port that did not win last.
//    - A clear request has priority over pending writes. It issues NREG
//      back-to-back zero writes to addresses 0..NREG-1.
//
// Parameters:
//    DATA_W      register data width
//    ADDR_W      register address width (NREG = 2**ADDR_W registers)
//
// Ports:
//    i_clk                 sole clock, rising edge
//    i_rst                 synchronous active-high reset
//    i_a_valid/addr/data   requester A write request
//    o_a_ready             requester A accept (combinational)
//    i_b_valid/addr/data   requester B write request
//    o_b_ready             requester B accept (combinational)
//    i_clr_req             level-sensitive request to zero all registers
//    o_clr_busy            clear sequence in progress
//    o_clr_done            one-cycle pulse alongside the final clear write
//    o_rf_we/waddr/wdata   registered register-file write port

module rf_wr_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,

   input  logic              i_a_valid,
   input  logic [ADDR_W-1:0] i_a_addr,
   input  logic [DATA_W-1:0] i_a_data,
   output logic              o_a_ready,

   input  logic              i_b_valid,
   input  logic [ADDR_W-1:0] i_b_addr,
   input  logic [DATA_W-1:0] i_b_data,
   output logic              o_b_ready,

   input  logic              i_clr_req,
   output logic              o_clr_busy,
   output logic              o_clr_done,

   output logic              o_rf_we,
   output logic [ADDR_W-1:0] o_rf_waddr,
   output logic [DATA_W-1:0] o_rf_wdata
);

   localparam int NREG = 2 ** ADDR_W;

   // The counter is one bit wider than the address. That way it cannot
   // wrap back to 0 on the final clear write.
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(NREG - 1);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic {
      ARB = 1'b0,
      CLR = 1'b1
   } state_t;

   state_t            state;
   logic              ptr;
   logic [ADDR_W:0]   cnt;

   logic              arb_open;
   logic              grant_a;
   logic              grant_b;
   logic              a_xfer;
   logic              b_xfer;

   // Grant decision for the current cycle. Requests are only accepted in
   // ARB, with no clear pending and outside reset.
   // - With both ports valid, ptr breaks the tie.
   // - Otherwise the single valid port wins.
   // The readies are gated by reset so they read 0 while i_rst is high,
   // even though the state itself only clears on the next edge.
   always_comb begin
      arb_open  = 1'b0;
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      arb_open  = !i_rst && (state == ARB) && !i_clr_req;
      grant_a   = i_a_valid && (!i_b_valid || !ptr);
      grant_b   = i_b_valid && (!i_a_valid ||  ptr);
   end

   assign o_a_ready  = arb_open && grant_a;
   assign o_b_ready  = arb_open && grant_b;
   assign a_xfer     = o_a_ready;
   assign b_xfer     = o_b_ready;

   // Busy reflects the clear state directly. It is forced low during
   // reset so that an aborted clear disappears immediately.
   assign o_clr_busy = !i_rst && (state == CLR);

   // Single sequential block for the state machine and registered outputs.
   //
   // ARB:
   //    - A clear request wins over any valid request. The next cycle is
   //      the first CLR cycle and issues no write.
   //    - Otherwise the winning transfer is registered onto the write port
   //      one cycle later, and ptr moves to favour the other requester.
   //
   // CLR:
   //    - Every edge registers a zero write to address cnt.
   //    - The edge that issues the last address also returns to ARB and
   //      raises o_clr_done. The pulse therefore lines up with that final
   //      write.
   //
   // Address and data hold their last values whenever no write is
   // issued, so downstream logic only has to qualify with o_rf_we.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ARB;
         ptr        <= 1'b0;
         cnt        <= '0;
         o_rf_we    <= 1'b0;
         o_rf_waddr <= '0;
         o_rf_wdata <= '0;
         o_clr_done <= 1'b0;
      end else begin
         case (state)
            ARB: begin
               o_clr_done <= 1'b0;
               if (i_clr_req) begin
                  state   <= CLR;
                  cnt     <= '0;
                  o_rf_we <= 1'b0;
               end else if (a_xfer) begin
                  o_rf_we    <= 1'b1;
                  o_rf_waddr <= i_a_addr;
                  o_rf_wdata <= i_a_data;
                  ptr        <= 1'b1;
               end else if (b_xfer) begin
                  o_rf_we    <= 1'b1;
                  o_rf_waddr <= i_b_addr;
                  o_rf_wdata <= i_b_data;
                  ptr        <= 1'b0;
               end else begin
                  o_rf_we <= 1'b0;
               end
            end

            CLR: begin
               o_rf_we    <= 1'b1;
               o_rf_waddr <= cnt[ADDR_W-1:0];
               o_rf_wdata <= '0;
               cnt        <= cnt + CNT_ONE;
               if (cnt == LAST_CNT) begin
                  state      <= ARB;
                  o_clr_done <= 1'b1;
               end else begin
                  o_clr_done <= 1'b0;
               end
            end

            default: begin
               state      <= ARB;
               o_rf_we    <= 1'b0;
               o_clr_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning register address width; NREG = 2**ADDR_W.
REQ-003 The block SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports i_a_valid in 1, i_a_addr in ADDR_W, i_a_data in DATA_W, and o_a_ready out 1: requester A write request.
REQ-006 The block SHALL have ports i_b_valid in 1, i_b_addr in ADDR_W, i_b_data in DATA_W, and o_b_ready out 1: requester B write request.
REQ-007 The block SHALL have port i_clr_req  in  1  request to zero all NREG registers.
REQ-008 The block SHALL have port o_clr_busy  out  1  clear sequence in progress.
REQ-009 The block SHALL have port o_clr_done  out  1  one-cycle pulse marking the final clear write.
REQ-010 The block SHALL have ports o_rf_we out 1, o_rf_waddr out ADDR_W, and o_rf_wdata out DATA_W: register-file write port, all registered.

Function
REQ-011 States SHALL be ARB and CLR.
- Transfer on a port = valid && ready in the same cycle.
- Requesters hold valid/addr/data stable until accepted.
REQ-012 In ARB with i_clr_req=0, o_a_ready/o_b_ready SHALL be combinational; exactly one is high iff at least one valid is high.
- Only one valid: that port is granted.
- Both valid: port selected by pointer ptr (0=A, 1=B) is granted.
REQ-013 ptr SHALL update at the clock edge after a transfer: ptr<=1 after an A transfer, ptr<=0 after a B transfer; otherwise it holds.
REQ-014 A transfer in cycle N SHALL produce o_rf_we=1 with the accepted addr/data in cycle N+1 (latency 1), for exactly one cycle per transfer.
REQ-015 Back-to-back transfers SHALL give o_rf_we high in consecutive cycles; no bubble is inserted.
REQ-016 When no write is issued, o_rf_we SHALL be 0 and o_rf_waddr/o_rf_wdata SHALL hold their previous values.
REQ-017 In ARB with i_clr_req=1, both readies SHALL be 0, and the next edge SHALL move to CLR with clear counter cnt<=0. Clear has priority over pending requests.
REQ-018 In CLR, each edge SHALL register o_rf_we=1, o_rf_waddr=cnt, o_rf_wdata=0, then cnt<=cnt+1. This gives NREG consecutive writes to addresses 0..NREG-1 in ascending order.
REQ-019 At the edge issuing address NREG-1, state SHALL return to ARB and o_clr_done SHALL be registered high, so it coincides with that write cycle for one cycle.
REQ-020 o_clr_busy SHALL equal (state==CLR), i.e. high for exactly NREG cycles per clear.
REQ-021 In CLR, both readies SHALL be 0, i_clr_req SHALL be ignored, and ptr SHALL hold.
REQ-022 In the first ARB cycle after CLR, requests SHALL be arbitrated normally.
- If i_clr_req is still 1, a new clear SHALL start, since the clear request is level-sensitive.
REQ-023 cnt SHALL be ADDR_W+1 bits wide or otherwise SHALL stop without wrap-around before re-entering address 0.

Reset
REQ-024 While i_rst=1 at a rising edge, the block SHALL set state=ARB, ptr=0, cnt=0, o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0, o_clr_done=0; o_clr_busy and readies SHALL read 0 during reset.
REQ-025 Reset asserted mid-clear or mid-transfer SHALL abort the operation; no further writes SHALL be issued for the aborted clear, and an unaccepted request SHALL remain pending for the requester.
REQ-026 The first cycle after i_rst deasserts SHALL be a normal ARB cycle.

Verification
REQ-027 Single-port write: A valid addr=5 data=0x3C in cycle N, B idle -> o_a_ready=1 in N; o_rf_we=1, waddr=5, wdata=0x3C in N+1 only.
REQ-028 Contention: A and B valid continuously from reset with ptr=0 -> grants alternate A,B,A,B; o_rf_we high every cycle starting 1 cycle after first grant.
REQ-029 Clear: i_clr_req pulsed 1 cycle in ARB with A valid -> o_a_ready=0; o_clr_busy high 8 cycles; o_rf_we high 8 consecutive cycles with waddr 0..7, wdata 0; o_clr_done high only with waddr=7; A accepted in the following ARB cycle.
REQ-030 Request during clear: B valid throughout CLR -> o_b_ready=0 for all 8 CLR cycles; B write appears 1 cycle after the first ARB cycle.
REQ-031 Reset mid-clear: i_rst=1 after waddr=3 issued -> next cycle o_rf_we=0, waddr=0, o_clr_busy=0, o_clr_done never asserted; ptr=0.
REQ-032 Hold behaviour: after one A write addr=2 data=0x11, all inputs idle 4 cycles -> o_rf_we=0, waddr=2, wdata=0x11 held.
